// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC output port.
// Contents: flit width, source select codes, one-hot turn codes,
// the flit type with X/Y destination accessors, and a helper that maps
// a source code onto its one-hot turn position.
package noc_pkg;

  localparam int FLIT_W = 8;

  localparam logic [2:0] SRC_N = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_E = 3'b010;
  localparam logic [2:0] SRC_W = 3'b011;
  localparam logic [2:0] SRC_L = 3'b100;

  localparam logic [4:0] TURN_N = 5'b10000;
  localparam logic [4:0] TURN_S = 5'b01000;
  localparam logic [4:0] TURN_E = 5'b00100;
  localparam logic [4:0] TURN_W = 5'b00010;
  localparam logic [4:0] TURN_L = 5'b00001;

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic logic [3:0] flit_x(input flit_t f);
    return f[7:4];
  endfunction

  function automatic logic [3:0] flit_y(input flit_t f);
    return f[3:0];
  endfunction

  // Undefined source codes map to no turn bit, so they can never match a grant.
  function automatic logic [4:0] src_to_turn(input logic [2:0] src);
    logic [4:0] t;
    case (src)
      SRC_N:   t = TURN_N;
      SRC_S:   t = TURN_S;
      SRC_E:   t = TURN_E;
      SRC_W:   t = TURN_W;
      SRC_L:   t = TURN_L;
      default: t = 5'b00000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/noc_output_port_if.sv
// Link bundle between route logic / downstream router and one output port.
// master: route logic + downstream side (drives candidate flits, select,
//         enable, credit return; observes turn, full, data, valid, err).
// slave : the output port itself.
interface noc_output_port_if;
  import noc_pkg::*;

  flit_t       n_data_i;
  flit_t       s_data_i;
  flit_t       e_data_i;
  flit_t       w_data_i;
  flit_t       l_data_i;
  logic [2:0]  select_i;
  logic        enable_i;
  logic [4:0]  turn_o;
  logic        port_full_o;
  flit_t       data_o;
  logic        valid_o;
  logic        credit_i;
  logic        err_o;

  modport master (
    output n_data_i, s_data_i, e_data_i, w_data_i, l_data_i,
    output select_i, enable_i, credit_i,
    input  turn_o, port_full_o, data_o, valid_o, err_o
  );

  modport slave (
    input  n_data_i, s_data_i, e_data_i, w_data_i, l_data_i,
    input  select_i, enable_i, credit_i,
    output turn_o, port_full_o, data_o, valid_o, err_o
  );
endinterface

// File: rtl/noc_fifo.sv
// Flit FIFO for the output port.
// Ports: clk, rst (sync, active-high, clears pointers/count only),
//        i_push/i_data write side, i_pop read side,
//        o_full/o_empty from the registered occupancy, o_head = oldest entry.
// Callers must not push when full or pop when empty.
module noc_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_push,
  input  flit_t i_data,
  input  logic  i_pop,
  output logic  o_full,
  output logic  o_empty,
  output flit_t o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  flit_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/noc_output_port.sv
// One router output direction: rotating one-hot grant, granted-source
// write into a flit FIFO, credit-based send to the downstream router,
// and a sticky protocol-error flag.
// Ports: clk, rst (sync, active-high); io_port (slave side of
//        noc_output_port_if) carrying candidate flits, select/enable,
//        turn grant, port_full, data/valid out, credit return, err.
module noc_output_port
  import noc_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter int         CREDITS  = 4,
  parameter logic [4:0] SRC_MASK = 5'b11111
) (
  input  logic               clk,
  input  logic               rst,
  noc_output_port_if.slave   io_port
);
  localparam int CRW = $clog2(CREDITS + 1);

  logic [4:0]     r_turn;
  logic [CRW-1:0] r_credits;
  logic           r_err;

  flit_t          w_sel_data;
  logic [4:0]     w_sel_turn;
  logic           w_sel_ok;
  logic           w_push;
  logic           w_wr_err;
  logic           w_credit_err;
  logic           w_send;
  logic           w_full;
  logic           w_empty;
  flit_t          w_head;

  // Reset grant: highest-priority present source.
  function automatic logic [4:0] first_turn();
    logic [4:0] t;
    t = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      if (SRC_MASK[i]) t = 5'(5'b00001 << i);
    end
    return t;
  endfunction

  // Rotate right, skipping absent sources; a lone source keeps the grant.
  function automatic logic [4:0] next_turn(input logic [4:0] cur);
    logic [4:0] n;
    logic [4:0] res;
    logic       found;
    n     = cur;
    res   = cur;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n = {n[0], n[4:1]};
      if (!found && ((n & SRC_MASK) != 5'b00000)) begin
        res   = n;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    w_sel_data = '0;
    case (io_port.select_i)
      SRC_N:   w_sel_data = io_port.n_data_i;
      SRC_S:   w_sel_data = io_port.s_data_i;
      SRC_E:   w_sel_data = io_port.e_data_i;
      SRC_W:   w_sel_data = io_port.w_data_i;
      SRC_L:   w_sel_data = io_port.l_data_i;
      default: w_sel_data = '0;
    endcase
  end

  // A write is legal only for a defined, present source holding the grant
  // while the FIFO (by registered occupancy) has room; anything else is
  // discarded and flagged.
  assign w_sel_turn = src_to_turn(io_port.select_i);
  assign w_sel_ok   = ((w_sel_turn & r_turn) != 5'b00000) &&
                      ((w_sel_turn & SRC_MASK) != 5'b00000);
  assign w_push     = io_port.enable_i && !w_full && w_sel_ok;
  assign w_wr_err   = io_port.enable_i && !w_push;

  // Gated by rst so nothing leaves the port in the reset cycle.
  assign w_send       = !rst && !w_empty && (r_credits != '0);
  assign w_credit_err = io_port.credit_i && !w_send && (r_credits == CRW'(CREDITS));

  noc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_sel_data),
    .i_pop   (w_send),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_turn    <= first_turn();
      r_credits <= CRW'(CREDITS);
      r_err     <= 1'b0;
    end else begin
      r_turn <= next_turn(r_turn);
      // Send and credit return together cancel out.
      if (w_send && !io_port.credit_i)
        r_credits <= r_credits - CRW'(1);
      else if (!w_send && io_port.credit_i && (r_credits != CRW'(CREDITS)))
        r_credits <= r_credits + CRW'(1);
      if (w_wr_err || w_credit_err) r_err <= 1'b1;
    end
  end

  assign io_port.turn_o      = r_turn;
  assign io_port.port_full_o = w_full;
  assign io_port.valid_o     = w_send;
  assign io_port.data_o      = w_send ? w_head : '0;
  assign io_port.err_o       = r_err;
endmodule

// File: doc/noc_output_port.md
# noc_output_port

One instance per router output direction (N, S, E, W, L), directly downstream of the route logic. Generates the rotating one-hot `turn` grant the route logic checks, accepts the single granted flit through `select`/`enable`, buffers it in a small FIFO, and drives the outgoing link under credit-based flow control. Reports `port_full` back to the route logic.

## Interface
- `DEPTH`, 4: output FIFO entries (power of two, 2..16)
- `CREDITS`, 4: downstream buffer slots; initial and maximum credit count
- `SRC_MASK`, 5'b11111: bit per source {N,S,E,W,L} (bit4=N … bit0=L); 0 = source absent, skipped by turn rotation
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `n_data_i`, `s_data_i`, `e_data_i`, `w_data_i`, `l_data_i`  in  8 each  candidate flits from the input buffers; [7:4]=dest X, [3:0]=dest Y
- `select_i`  in  3  source code: 000=N, 001=S, 010=E, 011=W, 100=L
- `enable_i`  in  1  write selected flit this cycle
- `turn_o`  out  5  one-hot grant: 10000=N, 01000=S, 00100=E, 00010=W, 00001=L
- `port_full_o`  out  1  FIFO holds DEPTH flits
- `data_o`  out  8  flit to downstream router
- `valid_o`  out  1  `data_o` transferred this cycle
- `credit_i`  in  1  downstream freed one slot
- `err_o`  out  1  sticky protocol-error flag

## Operation
- Turn rotation: `turn_o` moves one position right each cycle (N→S→E→W→L→N), skipping bits with `SRC_MASK`=0. Rotates unconditionally, whether or not the granted source wrote. With one enabled source, `turn_o` is constant.
- Write: when `enable_i` is high and `port_full_o` is low, the flit selected by `select_i` is pushed. `select_i` must match the source granted by `turn_o`.
- Send: `valid_o` = FIFO not empty AND credit count > 0. When `valid_o` is high, the FIFO head on `data_o` pops and the credit count decrements.
- Credits: the counter is `$clog2(CREDITS+1)` bits. `credit_i` increments it.
  - Send and `credit_i` in the same cycle: count unchanged.
  - `credit_i` while count = CREDITS: ignored, sets `err_o`.
- Errors set sticky `err_o`, cleared only by `rst`. Each such write is discarded and the FIFO is unchanged.
  - `enable_i` while `port_full_o` is high: the flit is dropped.
  - `select_i` of 101..111 with `enable_i`.
  - `select_i` with `enable_i` not matching the granted `turn_o` bit.
  - `select_i` with `enable_i` naming a source masked off by `SRC_MASK`.
- Pointers wrap modulo DEPTH. Occupancy counter is `$clog2(DEPTH+1)` bits.

## Timing
- Reset values:
  - `turn_o` = highest set bit of `SRC_MASK` (10000 with the default mask)
  - FIFO empty; `port_full_o`=0, `valid_o`=0, `data_o`=8'h00
  - credit count = CREDITS
  - `err_o`=0
- `turn_o`, `port_full_o`, and the occupancy and credit counters are registered. The route logic samples them combinationally in the same cycle it drives `select_i`/`enable_i`.
- `data_o` and `valid_o` are combinational from registered state: the FIFO head, the occupancy count, and the credit count.
- Latency: a flit written in cycle t appears on `data_o` with `valid_o` at t+1 at the earliest, if credits > 0.
- Full-gate uses registered occupancy. A push in a full cycle is rejected even if a pop happens in the same cycle. `port_full_o` falls the cycle after the pop.
- Push and pop in the same cycle with 0 < occupancy < DEPTH: occupancy unchanged.
- `credit_i` received at t makes a send possible at t+1.
- `rst` mid-operation: buffered flits are discarded, credits restored to CREDITS. No `valid_o` in the reset cycle or the cycle after.

## Structure
- `noc_pkg` holds:
  - `FLIT_W`=8
  - source codes `SRC_N`..`SRC_L` (3'b000..3'b100)
  - one-hot turn constants `TURN_N`..`TURN_L` (5'b10000..5'b00001)
  - typedef `flit_t` (`logic [7:0]`) with X/Y field accessors
- Sub-module `noc_fifo`: parameterised by DEPTH, with push/pop/full/empty/head ports.
- The turn rotator, source mux and credit counter stay in `noc_output_port`.

## Test plan
- Reset, then idle 10 cycles:
  - `turn_o` sequence 10000,01000,00100,00010,00001,10000,…
  - `valid_o`=0 throughout
  - `err_o`=0
- `SRC_MASK`=5'b10101: `turn_o` cycles 10000→00100→00001→10000. Write with `select_i`=001 → flit dropped, `err_o`=1.
- Write `l_data_i`=8'h23 with `select_i`=100 while `turn_o`=00001 at t, no back-pressure:
  - `data_o`=8'h23, `valid_o`=1 at t+1
  - credit count 4→3
- Hold `credit_i`=0 and write 8 flits:
  - 4 sent, 4 buffered
  - `port_full_o`=1
  - 9th write dropped, `err_o`=1
  - one `credit_i` pulse → one flit out next cycle, `port_full_o`=0 the cycle after
- `credit_i` asserted in the same cycle as a send with count=2 → count stays 2. `credit_i` with count=4 → `err_o`=1, count stays 4.
- Fill FIFO with 3 flits, assert `rst` for one cycle:
  - FIFO empty, credits=4
  - `turn_o`=10000
  - no stale flit on a later `valid_o`
